seq_1010_tx: RTL and testbench
==============================

SEQ_1010_TX -- requirements
Module: seq_1010_tx

Interface
REQ-001 SHALL have parameter GAP, default 0, meaning the number of idle (0) bits inserted between consecutive frames; legal range 0..3.
REQ-002 SHALL have parameter PAT_W, default 4, meaning the frame width in bits.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  transmit request, sampled only in IDLE.
REQ-006 SHALL have port pattern  input  PAT_W  frame bits, sent MSB first; the nominal value is 4'b1010.
REQ-007 SHALL have port count  input  4  number of frames to send, 1..15.
REQ-008 SHALL have port x  output  1  serial bit stream driving a sequence detector's x input.
REQ-009 SHALL have port busy  output  1  high while a transmission is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at the end of a completed transmission.
REQ-011 SHALL have port frame_cnt  output  4  number of frames fully sent in the current or last transmission.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, SEND, GAP and DONE; all outputs SHALL be registered and SHALL be functions of state only.
REQ-013 In IDLE, start=1 with count!=0 at edge N SHALL latch pattern and count, clear frame_cnt and bit index, and enter SEND.
REQ-014 In SEND, x SHALL equal pattern[PAT_W-1] from cycle N+1, and SHALL then advance one bit per clock, MSB to LSB; each bit is held for exactly one cycle.
REQ-015 After the LSB, frame_cnt SHALL increment; the FSM SHALL then go to GAP if GAP>0 and frames remain, to SEND if GAP=0 and frames remain, else to DONE.
REQ-016 In GAP, x SHALL be 0 for exactly GAP cycles, after which the FSM SHALL return to SEND with the bit index reset to the MSB.
REQ-017 GAP bits SHALL NOT be emitted after the last frame.
REQ-018 DONE SHALL last one cycle with done=1, busy=0 and x=0, then return to IDLE.
REQ-019 busy SHALL be 1 in SEND and GAP only; x SHALL be 0 in IDLE and DONE.
REQ-020 start while busy SHALL be ignored, and changes to pattern or count during a transmission SHALL have no effect.
REQ-021 start with count=0 SHALL be ignored: the FSM stays in IDLE and busy and done stay 0.
REQ-022 Total transmission latency SHALL be count*PAT_W + (count-1)*GAP cycles of busy, followed by one done cycle.
REQ-023 frame_cnt SHALL hold its final value after DONE until the next accepted start; it cannot wrap because count is at most 15.
REQ-024 A start in the same cycle as DONE SHALL be ignored; the earliest acceptable start is the first IDLE cycle.

Reset
REQ-025 rst=0 SHALL immediately and asynchronously force IDLE, x=0, busy=0, done=0 and frame_cnt=0, including mid-frame.
REQ-026 After rst deasserts, the block SHALL accept start on the first rising edge.
REQ-027 A transmission interrupted by reset SHALL NOT resume and SHALL NOT pulse done.

Configuration
REQ-028 Macro SEQ_1010_TX_ABORT_EN defined SHALL add port abort (input, 1 bit); abort=1 in SEND or GAP SHALL force IDLE on the next edge with x=0 and busy=0, SHALL NOT pulse done, and SHALL leave frame_cnt at the number of frames fully sent.
REQ-029 Macro SEQ_1010_TX_ABORT_EN undefined SHALL remove the abort port; a transmission always runs to DONE.

Verification
REQ-030 Case 1 (GAP=0): reset, then start with pattern=1010 and count=1 -> x=1,0,1,0 on cycles N+1..N+4, done=1 on N+5, frame_cnt=1.
REQ-031 Case 2 (GAP=0): pattern=1010, count=3 -> x=101010101010 contiguous, busy for 12 cycles, a non-overlap 1010 detector on x asserts y 3 times, frame_cnt=3.
REQ-032 Case 3 (GAP=2): pattern=1010, count=2 -> x=1010 00 1010, busy for 10 cycles, done on the 11th cycle.
REQ-033 Case 4: start pulsed mid-transmission and pattern changed to 1111 mid-transmission -> output stream unchanged; start with count=0 -> busy never rises.
REQ-034 Case 5: rst=0 asserted after the 2nd bit of frame 2 -> x=0, busy=0 and frame_cnt=0 immediately, with no done pulse; a new start on the first edge after release is accepted.
REQ-035 Case 6 (SEQ_1010_TX_ABORT_EN defined): abort during the bit-1 position of frame 3 with count=5 -> IDLE next cycle, frame_cnt=2, done stays 0.

Source files
------------

// File: rtl/seq_1010_tx.sv
// Serial frame transmitter: sends `count` copies of `pattern` MSB first, with GAP idle bits between frames.
// Optional abort input is enabled by defining SEQ_1010_TX_ABORT_EN.
module seq_1010_tx #(
    parameter int GAP   = 0,
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       count,
`ifdef SEQ_1010_TX_ABORT_EN
    input  logic             abort,
`endif
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [3:0]       frame_cnt
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);
    localparam logic [1:0]       GAP_LAST = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [PAT_W-1:0] pat_reg;
    logic [3:0]       cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [1:0]       gap_reg;
    logic             x_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [3:0]       fc_reg;
    logic             abort_hit;

`ifdef SEQ_1010_TX_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Outputs are loaded together with the state they belong to, so they stay pure state functions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            pat_reg   <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            gap_reg   <= '0;
            x_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            fc_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start && count != 4'd0) begin
                        pat_reg   <= pattern;
                        cnt_reg   <= count;
                        fc_reg    <= '0;
                        idx_reg   <= IDX_MSB;
                        x_reg     <= pattern[PAT_W-1];
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort_hit) begin
                        x_reg     <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (idx_reg != '0) begin
                        idx_reg <= idx_reg - IDX_W'(1);
                        x_reg   <= pat_reg[idx_reg - IDX_W'(1)];
                    end else begin
                        fc_reg <= fc_reg + 4'd1;
                        if ((fc_reg + 4'd1) < cnt_reg) begin
                            if (GAP > 0) begin
                                gap_reg   <= GAP_LAST;
                                x_reg     <= 1'b0;
                                state_reg <= ST_GAP;
                            end else begin
                                idx_reg <= IDX_MSB;
                                x_reg   <= pat_reg[PAT_W-1];
                            end
                        end else begin
                            x_reg     <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort_hit) begin
                        x_reg     <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (gap_reg == 2'd0) begin
                        idx_reg   <= IDX_MSB;
                        x_reg     <= pat_reg[PAT_W-1];
                        state_reg <= ST_SEND;
                    end else begin
                        gap_reg <= gap_reg - 2'd1;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not sampled here
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    x_reg     <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign x         = x_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign frame_cnt = fc_reg;

endmodule

// File: tb/tb_seq_1010_tx.sv
// Bench for seq_1010_tx: two instances (GAP=0 and GAP=2) share stimulus and are checked against a stream model.
module tb_seq_1010_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] count;
    logic       x0, busy0, done0;
    logic       x2, busy2, done2;
    logic [3:0] fc0, fc2;
`ifdef SEQ_1010_TX_ABORT_EN
    logic       abort0, abort2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_1010_tx #(.GAP(0), .PAT_W(4)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .count(count),
`ifdef SEQ_1010_TX_ABORT_EN
        .abort(abort0),
`endif
        .x(x0), .busy(busy0), .done(done0), .frame_cnt(fc0)
    );

    seq_1010_tx #(.GAP(2), .PAT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .count(count),
`ifdef SEQ_1010_TX_ABORT_EN
        .abort(abort2),
`endif
        .x(x2), .busy(busy2), .done(done2), .frame_cnt(fc2)
    );

    // Stream model: frames of 4 bits followed by g zero bits, no trailing gap.
    function automatic int tx_len(int cnt, int g);
        return cnt * 4 + (cnt - 1) * g;
    endfunction

    function automatic logic exp_x(logic [3:0] pat, int g, int k);
        int p = k % (4 + g);
        return (p < 4) ? pat[3 - p] : 1'b0;
    endfunction

    function automatic logic [3:0] exp_fc(int g, int k);
        return 4'(k / (4 + g) + (((k % (4 + g)) >= 4) ? 1 : 0));
    endfunction

    task automatic test_reset;
        #1;
        checks++;
        if ({x0, busy0, done0, fc0, x2, busy2, done2, fc2} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", {x0, busy0, done0, fc0, x2, busy2, done2, fc2});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({x0, busy0, done0, fc0, x2, busy2, done2, fc2} !== 14'd0) begin
            errors++;
            $display("FAIL reset_held got=%h exp=0", {x0, busy0, done0, fc0, x2, busy2, done2, fc2});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("reset: outputs idle after reset");
    endtask

    // One full transmission; optional start/pattern/count disturbance mid-frame and a start during DONE.
    task automatic test_frames(input logic [3:0] pat, input int cnt, input bit perturb, input bit start_in_done);
        int l0 = tx_len(cnt, 0);
        int l2 = tx_len(cnt, 2);
        int last = l2 + 2;
        int hits = 0;
        int nb = 0;
        logic [3:0] hist = 4'd0;
        logic ex, eb, ed;
        logic [3:0] ef;
        int err_before = errors;

        start   = 1'b1;
        pattern = pat;
        count   = 4'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (k < l0) begin
                ex = exp_x(pat, 0, k); eb = 1'b1; ed = 1'b0; ef = exp_fc(0, k);
            end else begin
                ex = 1'b0; eb = 1'b0; ed = (k == l0); ef = 4'(cnt);
            end
            checks++;
            if ({x0, busy0, done0, fc0} !== {ex, eb, ed, ef}) begin
                errors++;
                $display("FAIL g0_stream k=%0d got x/busy/done/fc=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                         k, x0, busy0, done0, fc0, ex, eb, ed, ef);
            end
            if (k < l2) begin
                ex = exp_x(pat, 2, k); eb = 1'b1; ed = 1'b0; ef = exp_fc(2, k);
            end else begin
                ex = 1'b0; eb = 1'b0; ed = (k == l2); ef = 4'(cnt);
            end
            checks++;
            if ({x2, busy2, done2, fc2} !== {ex, eb, ed, ef}) begin
                errors++;
                $display("FAIL g2_stream k=%0d got x/busy/done/fc=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                         k, x2, busy2, done2, fc2, ex, eb, ed, ef);
            end
            if (k < l0) begin
                hist = {hist[2:0], x0};
                nb++;
                if (nb >= 4 && hist == 4'b1010) begin
                    hits++;
                    nb = 0;
                end
            end
            if (perturb && k == 2) begin
                start   = 1'b1;
                pattern = 4'b1111;
                count   = 4'($urandom_range(0, 15));
            end
            if (perturb && k == 3) start = 1'b0;
            if (start_in_done && k == l0) start = 1'b1;
            if (start_in_done && k == l0 + 1) start = 1'b0;
            @(posedge clk);
            #1;
        end
        if (pat == 4'b1010) begin
            checks++;
            if (hits != cnt) begin
                errors++;
                $display("FAIL detector_hits got=%0d exp=%0d", hits, cnt);
            end
        end
        $display("tx: pattern=%b count=%0d perturb=%0d start_in_done=%0d len0=%0d len2=%0d errs=%0d",
                 pat, cnt, perturb, start_in_done, l0, l2, errors - err_before);
    endtask

    task automatic test_count_zero;
        start   = 1'b1;
        pattern = 4'b1010;
        count   = 4'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busy0, done0, x0, busy2, done2, x2} !== 6'd0) begin
                errors++;
                $display("FAIL count_zero k=%0d got=%b exp=000000", k, {busy0, done0, x0, busy2, done2, x2});
            end
        end
        start = 1'b0;
        count = 4'd1;
        $display("tx: count=0 start ignored");
    endtask

    task automatic test_reset_mid;
        logic [3:0] np = 4'($urandom);
        logic ex, eb, ed;
        start   = 1'b1;
        pattern = 4'b1010;
        count   = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            checks++;
            if ({x0, busy0} !== {exp_x(4'b1010, 0, k), 1'b1}) begin
                errors++;
                $display("FAIL rmid_pre k=%0d got x/busy=%b/%b exp=%b/1", k, x0, busy0, exp_x(4'b1010, 0, k));
            end
            if (k < 5) begin
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({x0, busy0, done0, fc0, x2, busy2, done2, fc2} !== 14'd0) begin
            errors++;
            $display("FAIL rmid_async got=%h exp=0", {x0, busy0, done0, fc0, x2, busy2, done2, fc2});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done0, busy0, done2, busy2} !== 4'd0) begin
            errors++;
            $display("FAIL rmid_nodone got=%b exp=0000", {done0, busy0, done2, busy2});
        end
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b1;
        pattern = np;
        count   = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({x0, busy0, done0, fc0, x2, busy2, done2, fc2} !== {np[3], 1'b1, 1'b0, 4'd0, np[3], 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL rmid_restart got=%h exp=%h", {x0, busy0, done0, fc0, x2, busy2, done2, fc2},
                     {np[3], 1'b1, 1'b0, 4'd0, np[3], 1'b1, 1'b0, 4'd0});
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            ex = (k < 4) ? np[3 - k] : 1'b0;
            eb = (k < 4);
            ed = (k == 4);
            checks++;
            if ({x0, busy0, done0, x2, busy2, done2} !== {ex, eb, ed, ex, eb, ed}) begin
                errors++;
                $display("FAIL rmid_run k=%0d got=%b exp=%b", k, {x0, busy0, done0, x2, busy2, done2},
                         {ex, eb, ed, ex, eb, ed});
            end
        end
        $display("tx: reset mid-frame then restart pattern=%b", np);
    endtask

`ifdef SEQ_1010_TX_ABORT_EN
    task automatic test_abort;
        logic [3:0] pat = 4'($urandom);
        start   = 1'b1;
        pattern = pat;
        count   = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            checks++;
            if (k <= 9) begin
                if ({x0, busy0, done0} !== {exp_x(pat, 0, k), 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL abort_g0_run k=%0d got=%b exp=%b", k, {x0, busy0, done0}, {exp_x(pat, 0, k), 2'b10});
                end
            end else if ({x0, busy0, done0, fc0} !== {3'b000, 4'd2}) begin
                errors++;
                $display("FAIL abort_g0_idle k=%0d got x/busy/done/fc=%b/%b/%b/%0d exp=0/0/0/2", k, x0, busy0, done0, fc0);
            end
            checks++;
            if (k <= 13) begin
                if ({x2, busy2, done2} !== {exp_x(pat, 2, k), 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL abort_g2_run k=%0d got=%b exp=%b", k, {x2, busy2, done2}, {exp_x(pat, 2, k), 2'b10});
                end
            end else if ({x2, busy2, done2, fc2} !== {3'b000, 4'd2}) begin
                errors++;
                $display("FAIL abort_g2_idle k=%0d got x/busy/done/fc=%b/%b/%b/%0d exp=0/0/0/2", k, x2, busy2, done2, fc2);
            end
            abort0 = (k == 9);
            abort2 = (k == 13);
            @(posedge clk);
            #1;
        end
        abort0 = 1'b0;
        abort2 = 1'b0;
        $display("tx: abort in frame 3 of 5 pattern=%b", pat);
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            test_frames(4'($urandom), $urandom_range(1, 15), bit'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        pattern = 4'd0;
        count   = 4'd0;
`ifdef SEQ_1010_TX_ABORT_EN
        abort0  = 1'b0;
        abort2  = 1'b0;
`endif
        test_reset;
        test_frames(4'b1010, 1, 1'b0, 1'b0);
        test_frames(4'b1010, 3, 1'b0, 1'b0);
        test_frames(4'b1010, 2, 1'b0, 1'b0);
        test_frames(4'b1010, 4, 1'b1, 1'b0);
        test_count_zero;
        test_frames(4'b1101, 1, 1'b0, 1'b1);
        test_frames(4'b0110, 2, 1'b0, 1'b1);
        test_reset_mid;
`ifdef SEQ_1010_TX_ABORT_EN
        test_abort;
`endif
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
